// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared Breakout screen, ball and brick wall geometry
package breakout_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int R_BALL   = 8;

    localparam int N_COLS   = 8;
    localparam int N_ROWS   = 4;
    localparam int BRICK_W  = 80;
    localparam int BRICK_H  = 16;
    localparam int WALL_TOP = 48;
    localparam int N_BRICKS = N_COLS * N_ROWS;
    localparam int SCORE_W  = 10;

    typedef enum logic [2:0] {
        IDLE,
        P_UP,
        P_DOWN,
        P_LEFT,
        P_RIGHT
    } probe_state_t;

    // N_COLS is a power of two, so row*N_COLS+col is a plain concatenation
    function automatic logic [4:0] cell_index(input logic [1:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/brick_cell_locate.sv
// rtl/brick_cell_locate.sv - maps a screen point to its brick cell with constant compares
module brick_cell_locate
    import breakout_pkg::*;
(
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       valid,
    output logic [1:0] row,
    output logic [2:0] col
);

    always_comb begin
        col = '0;
        row = '0;
        for (int c = 1; c < N_COLS; c++) begin
            if (px >= 10'(c * BRICK_W)) col = 3'(c);
        end
        for (int r = 1; r < N_ROWS; r++) begin
            if (py >= 10'(WALL_TOP + r * BRICK_H)) row = 2'(r);
        end
        valid = (px < 10'(N_COLS * BRICK_W))
             && (py >= 10'(WALL_TOP))
             && (py < 10'(WALL_TOP + N_ROWS * BRICK_H));
    end

endmodule

// File: rtl/brick_wall.sv
// rtl/brick_wall.sv - Breakout brick bitmap, ball collision probing and pixel query
module brick_wall
    import breakout_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [9:0]         x_ball,
    input  logic [9:0]         y_ball,
    input  logic               ball_moved,
    input  logic [9:0]         x_pix,
    input  logic [9:0]         y_pix,
    output logic               brick_on,
    output logic [1:0]         brick_row,
    output logic               bounce_x,
    output logic               bounce_y,
    output logic [SCORE_W-1:0] score,
    output logic [5:0]         bricks_left,
    output logic               cleared
);

    probe_state_t          state;
    probe_state_t          miss_next;
    logic [9:0]            xs;
    logic [9:0]            ys;
    logic [N_BRICKS-1:0]   bitmap;
    logic                  pend_x;
    logic                  pend_y;

    logic [10:0]           x_sum;
    logic [10:0]           y_sum;
    logic [9:0]            probe_x;
    logic [9:0]            probe_y;
    logic                  probe_ok;
    logic                  probe_in_wall;
    logic [1:0]            probe_row;
    logic [2:0]            probe_col;
    logic [4:0]            probe_idx;
    logic                  probe_hit;
    logic [2:0]            points;
    logic [SCORE_W:0]      score_sum;
    logic [SCORE_W-1:0]    score_sat;

    logic                  pix_valid;
    logic [1:0]            pix_row;
    logic [2:0]            pix_col;

    assign cleared = (bricks_left == 6'd0);
    assign x_sum   = {1'b0, xs} + 11'(R_BALL);
    assign y_sum   = {1'b0, ys} + 11'(R_BALL);

    // Out-of-range probes are flagged invalid instead of being allowed to wrap
    always_comb begin
        probe_x   = xs;
        probe_y   = ys;
        probe_ok  = 1'b0;
        miss_next = IDLE;
        case (state)
            P_UP: begin
                probe_y   = ys - 10'(R_BALL);
                probe_ok  = (ys >= 10'(R_BALL));
                miss_next = P_DOWN;
            end
            P_DOWN: begin
                probe_y   = y_sum[9:0];
                probe_ok  = (y_sum < 11'(SCREEN_H));
                miss_next = P_LEFT;
            end
            P_LEFT: begin
                probe_x   = xs - 10'(R_BALL);
                probe_ok  = (xs >= 10'(R_BALL));
                miss_next = P_RIGHT;
            end
            P_RIGHT: begin
                probe_x   = x_sum[9:0];
                probe_ok  = (x_sum < 11'(SCREEN_W));
                miss_next = IDLE;
            end
            default: begin
                probe_ok  = 1'b0;
                miss_next = IDLE;
            end
        endcase
    end

    brick_cell_locate u_probe_loc (
        .px    (probe_x),
        .py    (probe_y),
        .valid (probe_in_wall),
        .row   (probe_row),
        .col   (probe_col)
    );

    brick_cell_locate u_pix_loc (
        .px    (x_pix),
        .py    (y_pix),
        .valid (pix_valid),
        .row   (pix_row),
        .col   (pix_col)
    );

    assign probe_idx = cell_index(probe_row, probe_col);
    assign probe_hit = probe_ok && probe_in_wall && bitmap[probe_idx];

    // Top row is worth the most points
    assign points    = 3'(N_ROWS) - {1'b0, probe_row};
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(points);
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    always_ff @(posedge clock) begin
        if (reset || !start) begin
            state       <= IDLE;
            xs          <= '0;
            ys          <= '0;
            bitmap      <= '1;
            score       <= '0;
            bricks_left <= 6'(N_BRICKS);
            pend_x      <= 1'b0;
            pend_y      <= 1'b0;
            bounce_x    <= 1'b0;
            bounce_y    <= 1'b0;
        end else begin
            bounce_x <= pend_x;
            bounce_y <= pend_y;
            pend_x   <= 1'b0;
            pend_y   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ball_moved && !cleared) begin
                        xs    <= x_ball;
                        ys    <= y_ball;
                        state <= P_UP;
                    end
                end
                P_UP, P_DOWN, P_LEFT, P_RIGHT: begin
                    if (probe_hit) begin
                        bitmap[probe_idx] <= 1'b0;
                        bricks_left       <= bricks_left - 6'd1;
                        score             <= score_sat;
                        pend_y            <= (state == P_UP) || (state == P_DOWN);
                        pend_x            <= (state == P_LEFT) || (state == P_RIGHT);
                        state             <= IDLE;
                    end else begin
                        state <= miss_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !start) begin
            brick_on  <= 1'b0;
            brick_row <= 2'd0;
        end else begin
            brick_on  <= pix_valid && bitmap[cell_index(pix_row, pix_col)];
            brick_row <= pix_valid ? pix_row : 2'd0;
        end
    end

endmodule

// File: tb/tb_brick_wall.sv
// tb/tb_brick_wall.sv - directed self-checking bench for brick_wall
module tb_brick_wall;

    logic       clock;
    logic       reset;
    logic       start;
    logic [9:0] x_ball;
    logic [9:0] y_ball;
    logic       ball_moved;
    logic [9:0] x_pix;
    logic [9:0] y_pix;
    logic       brick_on;
    logic [1:0] brick_row;
    logic       bounce_x;
    logic       bounce_y;
    logic [9:0] score;
    logic [5:0] bricks_left;
    logic       cleared;

    int n_checks = 0;
    int n_fail   = 0;

    brick_wall dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .ball_moved  (ball_moved),
        .x_pix       (x_pix),
        .y_pix       (y_pix),
        .brick_on    (brick_on),
        .brick_row   (brick_row),
        .bounce_x    (bounce_x),
        .bounce_y    (bounce_y),
        .score       (score),
        .bricks_left (bricks_left),
        .cleared     (cleared)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic move_ball(input int x, input int y);
        x_ball     = 10'(x);
        y_ball     = 10'(y);
        ball_moved = 1'b1;
        tick();
        ball_moved = 1'b0;
    endtask

    task automatic set_pix(input int x, input int y);
        x_pix = 10'(x);
        y_pix = 10'(y);
        tick();
    endtask

    int pulses;
    int hits;
    int got;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        x_ball     = '0;
        y_ball     = '0;
        ball_moved = 1'b0;
        x_pix      = 10'd85;
        y_pix      = 10'd50;

        // 1: reset state and pixel queries on a full wall
        tick();
        tick();
        check("rst_bricks_left", int'(bricks_left), 32);
        check("rst_score", int'(score), 0);
        check("rst_cleared", int'(cleared), 0);
        check("rst_bounce_x", int'(bounce_x), 0);
        check("rst_bounce_y", int'(bounce_y), 0);
        check("rst_brick_on", int'(brick_on), 0);
        reset = 1'b0;
        start = 1'b1;
        tick();
        check("pix_85_50_on", int'(brick_on), 1);
        check("pix_85_50_row", int'(brick_row), 0);
        set_pix(639, 111);
        check("pix_639_111_on", int'(brick_on), 1);
        check("pix_639_111_row", int'(brick_row), 3);
        set_pix(640, 60);
        check("pix_640_60_off", int'(brick_on), 0);
        set_pix(300, 47);
        check("pix_300_47_off", int'(brick_on), 0);
        set_pix(300, 112);
        check("pix_300_112_off", int'(brick_on), 0);
        set_pix(0, 48);
        check("pix_0_48_on", int'(brick_on), 1);

        // 2: UP probe hits cell 25, bounce_y at T+2
        move_ball(100, 119);
        tick();
        check("up_t1_bounce_y", int'(bounce_y), 0);
        check("up_bricks_left", int'(bricks_left), 31);
        check("up_score", int'(score), 1);
        tick();
        check("up_t2_bounce_y", int'(bounce_y), 1);
        check("up_t2_bounce_x", int'(bounce_x), 0);
        tick();
        check("up_t3_bounce_y", int'(bounce_y), 0);
        set_pix(100, 100);
        check("pix_100_100_cleared", int'(brick_on), 0);

        // 3: same ball again, every probe misses
        move_ball(100, 119);
        pulses = 0;
        repeat (4) begin
            tick();
            pulses += int'(bounce_x) + int'(bounce_y);
        end
        check("miss_pulses", pulses, 0);
        check("miss_bricks_left", int'(bricks_left), 31);
        check("miss_score", int'(score), 1);

        // 4: issued right at T+5 of step 3; RIGHT probe hits cell 26
        move_ball(156, 104);
        pulses = 0;
        repeat (4) begin
            tick();
            pulses += int'(bounce_x) + int'(bounce_y);
        end
        check("right_early_pulses", pulses, 0);
        tick();
        check("right_t5_bounce_x", int'(bounce_x), 1);
        check("right_t5_bounce_y", int'(bounce_y), 0);
        check("right_bricks_left", int'(bricks_left), 30);
        check("right_score", int'(score), 2);
        tick();
        check("right_t6_bounce_x", int'(bounce_x), 0);

        // 5: corner ball with invalid probes, then an abort mid-probe
        move_ball(4, 4);
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(bounce_x) + int'(bounce_y);
        end
        check("corner_pulses", pulses, 0);
        check("corner_bricks_left", int'(bricks_left), 30);
        check("corner_score", int'(score), 2);
        x_pix = 10'd100;
        y_pix = 10'd100;
        move_ball(236, 104);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(bounce_x) + int'(bounce_y);
        end
        check("abort_pulses", pulses, 0);
        check("abort_bricks_left", int'(bricks_left), 32);
        check("abort_score", int'(score), 0);
        check("abort_pix_restored_on", int'(brick_on), 1);
        check("abort_pix_restored_row", int'(brick_row), 3);

        // 6: clear the whole wall through UP-probe hits
        x_pix = 10'd85;
        y_pix = 10'd50;
        hits  = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                move_ball(c * 80 + 40, 64 + r * 16);
                got = 0;
                repeat (4) begin
                    tick();
                    if (bounce_y) got = 1;
                end
                hits += got;
            end
        end
        check("clear_hits", hits, 32);
        check("clear_score", int'(score), 80);
        check("clear_bricks_left", int'(bricks_left), 0);
        check("clear_cleared", int'(cleared), 1);
        check("clear_pix_off", int'(brick_on), 0);
        move_ball(360, 64);
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(bounce_x) + int'(bounce_y);
        end
        check("cleared_ignore_pulses", pulses, 0);
        check("cleared_score_hold", int'(score), 80);
        start = 1'b0;
        tick();
        check("rearm_cleared", int'(cleared), 0);
        check("rearm_bricks_left", int'(bricks_left), 32);
        check("rearm_score", int'(score), 0);
        start = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
